// File: rtl/pipelined_accuracy_controllable_adder_pkg.sv
// Shared arithmetic definitions for the accuracy-controllable adder:
// block geometry, stage-count derivation and the error-configurable bit cell.
package pipelined_accuracy_controllable_adder_pkg;

   localparam int BLK_W = 4;

   typedef struct packed {
      logic             co;
      logic [BLK_W-1:0] sum;
   } blk_res_t;

   function automatic int calc_nstg(input int len, input int blocks_per_stage);
      return len / (BLK_W * blocks_per_stage);
   endfunction

   // Returns {carry_out, sum}; er=1 is a full adder, er=0 the cheap approximation.
   function automatic logic [1:0] ec_add(input logic er, input logic a, input logic b, input logic ci);
      logic p;
      p = a ^ b;
      return {(er & b & ci) | ((b | ci) & a), ~(er & p & ci) & (p | ci)};
   endfunction

endpackage

// File: rtl/pipelined_accuracy_controllable_adder_if.sv
// Operand/result handshake bundle of the accuracy-controllable adder.
// slave is the adder side, master the producer/consumer side.
interface pipelined_accuracy_controllable_adder_if #(
   parameter int LEN     = 32,
   parameter int APX_LEN = 8
);
   logic               in_valid;
   logic               in_ready;
   logic               exact;
   logic [APX_LEN-1:0] Er;
   logic [LEN-1:0]     A;
   logic [LEN-1:0]     B;
   logic               Cin;
   logic               out_valid;
   logic               out_ready;
   logic [LEN-1:0]     Sum;
   logic               Cout;
   logic               out_exact;
   logic               busy;

   modport master (
      output in_valid, exact, Er, A, B, Cin, out_ready,
      input  in_ready, out_valid, Sum, Cout, out_exact, busy
   );

   modport slave (
      input  in_valid, exact, Er, A, B, Cin, out_ready,
      output in_ready, out_valid, Sum, Cout, out_exact, busy
   );
endinterface

// File: rtl/pipelined_accuracy_controllable_adder_block.sv
// One 4-bit block: block 0 ripples from the external carry, later blocks
// ripple from zero and pick sum or sum+1 from the incoming carry (purely combinational).
module approximate_carry_select_block
   import pipelined_accuracy_controllable_adder_pkg::*;
#(
   parameter bit APX   = 1'b1,
   parameter bit FIRST = 1'b0
) (
   input  logic [BLK_W-1:0] a_i,
   input  logic [BLK_W-1:0] b_i,
   input  logic [BLK_W-1:0] er_i,
   input  logic             c_i,
   output blk_res_t         res_o
);
   logic [BLK_W-1:0] er_eff;
   logic [BLK_W-1:0] sum_raw;
   logic [BLK_W:0]   ripple;
   logic [BLK_W:0]   inc;
   logic             sel;

   always_comb begin
      er_eff    = er_i | {BLK_W{~APX}};
      ripple    = '0;
      // With a zero carry into bit 0 the cell degenerates to a half adder, so Er has no effect there.
      ripple[0] = FIRST ? c_i : 1'b0;
      sum_raw   = '0;
      for (int i = 0; i < BLK_W; i++) begin
         {ripple[i+1], sum_raw[i]} = ec_add(er_eff[i], a_i[i], b_i[i], ripple[i]);
      end
      sel       = FIRST ? 1'b0 : c_i;
      inc       = {1'b0, sum_raw} + 5'd1;
      res_o.sum = sel ? inc[BLK_W-1:0] : sum_raw;
      res_o.co  = ripple[BLK_W] | (sel & inc[BLK_W]);
   end
endmodule

// File: rtl/pipelined_accuracy_controllable_adder.sv
// Pipelined approximate adder: NSTG stages of BLOCKS_PER_STAGE blocks, NSTG-cycle latency,
// one op per cycle; per-stage valid bits with ready rippling back combinationally from out_ready.
module pipelined_accuracy_controllable_adder
   import pipelined_accuracy_controllable_adder_pkg::*;
#(
   parameter int LEN              = 32,
   parameter int APX_LEN          = 8,
   parameter int BLOCKS_PER_STAGE = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   pipelined_accuracy_controllable_adder_if.slave bus
);
   localparam int NSTG = calc_nstg(LEN, BLOCKS_PER_STAGE);
   localparam int SW   = BLK_W * BLOCKS_PER_STAGE;

   logic [NSTG-1:0] vld_q, vld_d, adv, rdy, ld;
   logic [LEN-1:0]  er_full;

   always_comb begin
      er_full              = '1;
      er_full[APX_LEN-1:0] = bus.Er;
   end

   always_comb begin : flow
      logic nxt;
      nxt = bus.out_ready;
      adv = '0;
      rdy = '0;
      ld  = '0;
      for (int s = NSTG - 1; s >= 0; s--) begin
         adv[s] = vld_q[s] & nxt;
         rdy[s] = ~vld_q[s] | adv[s];
         nxt    = rdy[s];
      end
      ld[0] = bus.in_valid & rdy[0];
      for (int s = 1; s < NSTG; s++) begin
         ld[s] = vld_q[s-1] & rdy[s];
      end
      vld_d = ld | (vld_q & ~adv);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) vld_q <= '0;
      else        vld_q <= vld_d;
   end

   for (genvar s = 0; s < NSTG; s++) begin : gen_stg
      localparam int RIN  = LEN - s * SW;
      localparam int OUTW = (s + 1) * SW;

      logic [RIN-1:0]             a_in, b_in, er_in;
      logic                       c_in, x_in;
      logic [SW-1:0]              er_blk;
      wire  [SW-1:0]              blk_sum;
      wire  [BLOCKS_PER_STAGE:0]  cc;
      logic [OUTW-1:0]            sum_d, sum_q;
      logic                       c_q, x_q;

      if (s == 0) begin : g_src
         assign a_in  = bus.A;
         assign b_in  = bus.B;
         assign er_in = er_full;
         assign c_in  = bus.Cin;
         assign x_in  = bus.exact;
         assign sum_d = blk_sum;
      end else begin : g_src
         assign a_in  = gen_stg[s-1].g_fwd.a_q;
         assign b_in  = gen_stg[s-1].g_fwd.b_q;
         assign er_in = gen_stg[s-1].g_fwd.er_q;
         assign c_in  = gen_stg[s-1].c_q;
         assign x_in  = gen_stg[s-1].x_q;
         assign sum_d = {blk_sum, gen_stg[s-1].sum_q};
      end

      // Er travels raw with the op; the exact override is applied where each block consumes it.
      assign er_blk = er_in[SW-1:0] | {SW{x_in}};
      assign cc[0]  = c_in;

      for (genvar k = 0; k < BLOCKS_PER_STAGE; k++) begin : gen_blk
         localparam int IDX = s * BLOCKS_PER_STAGE + k;
         blk_res_t res;
         approximate_carry_select_block #(
            .APX   (IDX * BLK_W < APX_LEN),
            .FIRST (IDX == 0)
         ) u_blk (
            .a_i   (a_in[k*BLK_W +: BLK_W]),
            .b_i   (b_in[k*BLK_W +: BLK_W]),
            .er_i  (er_blk[k*BLK_W +: BLK_W]),
            .c_i   (cc[k]),
            .res_o (res)
         );
         assign blk_sum[k*BLK_W +: BLK_W] = res.sum;
         assign cc[k+1]                   = res.co;
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sum_q <= '0;
            c_q   <= 1'b0;
            x_q   <= 1'b0;
         end else if (ld[s]) begin
            sum_q <= sum_d;
            c_q   <= cc[BLOCKS_PER_STAGE];
            x_q   <= x_in;
         end
      end

      if (s < NSTG - 1) begin : g_fwd
         localparam int ROUT = LEN - (s + 1) * SW;
         logic [ROUT-1:0] a_q, b_q, er_q;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               a_q  <= '0;
               b_q  <= '0;
               er_q <= '0;
            end else if (ld[s]) begin
               a_q  <= a_in[RIN-1:SW];
               b_q  <= b_in[RIN-1:SW];
               er_q <= er_in[RIN-1:SW];
            end
         end
      end
   end

   assign bus.in_ready  = rdy[0];
   assign bus.out_valid = vld_q[NSTG-1];
   assign bus.busy      = |vld_q;
   assign bus.Sum       = gen_stg[NSTG-1].sum_q;
   assign bus.Cout      = gen_stg[NSTG-1].c_q;
   assign bus.out_exact = gen_stg[NSTG-1].x_q;
endmodule
